// File: rtl/int_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
// Pure declarations; no timing or flow control.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int              NSRC_DEF       = 4;
    localparam int              PCW_DEF        = 10;
    localparam logic [9:0]      VEC_BASE_DEF   = 10'h3C0;
    localparam int              VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/sync_edge.sv
// Single-bit 2-flop synchronizer with rising-edge detect; o_rise is valid
// two clocks after the input rises and lasts one cycle. No backpressure.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/int_ctrl.sv
// One-level vectored interrupt controller: edge capture, fixed priority, PC/Z save
// and restore. Entry pulse one cycle after selection; ret honoured combinationally.
module int_ctrl
    import int_pkg::*;
#(
    parameter int             NSRC       = NSRC_DEF,
    parameter int             PCW        = PCW_DEF,
    parameter logic [PCW-1:0] VEC_BASE   = PCW'(VEC_BASE_DEF),
    parameter int             VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_d,
    input  logic [PCW-1:0]  pc_next,
    input  logic            z_in,
    input  logic            ret,
    output logic            take,
    output logic [PCW-1:0]  vec,
    output logic            pc_ret_sel,
    output logic [PCW-1:0]  pc_ret,
    output logic            z_restore,
    output logic            z_ret,
    output logic [NSRC-1:0] mask_q,
    output logic [NSRC-1:0] pend_q,
    output logic            busy
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] w_win_idx;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_req;
    logic [NSRC-1:0] w_clr;
    logic [PCW-1:0]  r_saved_pc;
    logic            r_saved_z;
    logic            w_enter;
    logic [PCW-1:0]  w_vec_calc;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
            sync_edge u_sync (
                .clk    (clk),
                .reset  (reset),
                .i_d    (irq_src[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_req = r_pend & r_mask;

    // Scan high to low so the lowest set index wins.
    always_comb begin
        w_win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_idx = IDXW'(i);
            end
        end
    end

    assign w_enter = (r_state == IDLE) && (|w_req);
    assign w_clr   = w_enter ? (NSRC'(1) << w_win_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_mask     <= '0;
            r_pend     <= '0;
            r_saved_pc <= '0;
            r_saved_z  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A fresh edge in the clearing cycle must not be lost.
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_d;
            end
            if (w_enter) begin
                r_idx      <= w_win_idx;
                r_saved_pc <= pc_next;
                r_saved_z  <= z_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        take        = 1'b0;
        pc_ret_sel  = 1'b0;
        z_restore   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ENTER;
                end
            end
            ENTER: begin
                take        = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                busy = 1'b1;
                if (ret) begin
                    pc_ret_sel  = 1'b1;
                    z_restore   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_vec_calc = VEC_BASE + PCW'(r_idx) * PCW'(VEC_STRIDE);
    assign vec        = take ? w_vec_calc : '0;
    assign pc_ret     = r_saved_pc;
    assign z_ret      = r_saved_z;
    assign mask_q     = r_mask;
    assign pend_q     = r_pend;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: scenario tasks plus a vector scoreboard fed by the stimulus.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_src = 4'b0000;
    logic       mask_we = 1'b0;
    logic [3:0] mask_d = 4'b0000;
    logic [9:0] pc_next = 10'h000;
    logic       z_in = 1'b0;
    logic       ret = 1'b0;

    logic       take;
    logic [9:0] vec;
    logic       pc_ret_sel;
    logic [9:0] pc_ret;
    logic       z_restore;
    logic       z_ret;
    logic [3:0] mask_q;
    logic [3:0] pend_q;
    logic       busy;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_take = 0;
    logic [9:0] exp_q[$];
    logic [9:0] sb_exp;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .pc_next    (pc_next),
        .z_in       (z_in),
        .ret        (ret),
        .take       (take),
        .vec        (vec),
        .pc_ret_sel (pc_ret_sel),
        .pc_ret     (pc_ret),
        .z_restore  (z_restore),
        .z_ret      (z_ret),
        .mask_q     (mask_q),
        .pend_q     (pend_q),
        .busy       (busy)
    );

    // Scoreboard: every take pops the oldest expected vector.
    always @(negedge clk) begin
        if (!reset && take) begin
            n_take++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_take: vec=%h, required no take", vec);
            end else begin
                sb_exp = exp_q.pop_front();
                if (vec !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_vec: got %h, expected %h", vec, sb_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ret_pulse();
        ret = 1'b1;
        cyc(1);
        ret = 1'b0;
    endtask

    task automatic test_reset();
        cyc(2);
        n_tests++;
        if ({take, vec, pc_ret_sel, pc_ret, z_restore, z_ret, mask_q, pend_q, busy} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got take=%b vec=%h sel=%b pc_ret=%h zr=%b z_ret=%b mask=%b pend=%b busy=%b, expected all 0",
                     take, vec, pc_ret_sel, pc_ret, z_restore, z_ret, mask_q, pend_q, busy);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic();
        int t0;
        pc_next = 10'h025; z_in = 1'b1;
        mask_we = 1'b1; mask_d = 4'b1111; irq_src[2] = 1'b1;
        exp_q.push_back(10'h3C8);
        cyc(1);
        mask_we = 1'b0;
        cyc(2);
        n_tests++;
        if (pend_q !== 4'b0100 || take !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pend: got pend=%b take=%b, expected pend=0100 take=0", pend_q, take);
        end
        t0 = n_take;
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3C8 || pend_q !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_enter: got take=%b vec=%h pend=%b busy=%b, expected 1 3c8 0000 1", take, vec, pend_q, busy);
        end
        cyc(1);
        n_tests++;
        if (take !== 1'b0 || busy !== 1'b1 || n_take - t0 !== 1) begin
            n_fail++;
            $display("FAIL basic_one_take: got take=%b busy=%b takes=%0d, expected 0 1 1", take, busy, n_take - t0);
        end
        ret = 1'b1;
        #1;
        n_tests++;
        if (pc_ret_sel !== 1'b1 || z_restore !== 1'b1 || pc_ret !== 10'h025 || z_ret !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ret: got sel=%b zr=%b pc_ret=%h z_ret=%b, expected 1 1 025 1", pc_ret_sel, z_restore, pc_ret, z_ret);
        end
        cyc(1);
        ret = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || pc_ret_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy=%b sel=%b, expected 0 0", busy, pc_ret_sel);
        end
        irq_src[2] = 1'b0;
        cyc(3);
    endtask

    task automatic test_priority();
        pc_next = 10'h1A3; z_in = 1'b0;
        irq_src[3] = 1'b1; irq_src[1] = 1'b1;
        exp_q.push_back(10'h3C4);
        exp_q.push_back(10'h3CC);
        cyc(3);
        n_tests++;
        if (pend_q !== 4'b1010) begin
            n_fail++;
            $display("FAIL prio_pend: got %b, expected 1010", pend_q);
        end
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3C4 || pend_q !== 4'b1000) begin
            n_fail++;
            $display("FAIL prio_first: got take=%b vec=%h pend=%b, expected 1 3c4 1000", take, vec, pend_q);
        end
        cyc(1);
        n_tests++;
        if (pc_ret !== 10'h1A3 || z_ret !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_saved: got pc_ret=%h z_ret=%b, expected 1a3 0", pc_ret, z_ret);
        end
        ret_pulse();
        n_tests++;
        if (busy !== 1'b0 || take !== 1'b0 || pend_q !== 4'b1000) begin
            n_fail++;
            $display("FAIL prio_return: got busy=%b take=%b pend=%b, expected 0 0 1000", busy, take, pend_q);
        end
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3CC || pend_q !== 4'b0000) begin
            n_fail++;
            $display("FAIL prio_b2b: got take=%b vec=%h pend=%b, expected 1 3cc 0000", take, vec, pend_q);
        end
        cyc(1);
        ret_pulse();
        irq_src = 4'b0000;
        cyc(3);
    endtask

    task automatic test_mask();
        int t0;
        mask_we = 1'b1; mask_d = 4'b1110;
        cyc(1);
        mask_we = 1'b0;
        irq_src[0] = 1'b1;
        cyc(3);
        t0 = n_take;
        cyc(4);
        n_tests++;
        if (pend_q !== 4'b0001 || busy !== 1'b0 || n_take !== t0 || mask_q !== 4'b1110) begin
            n_fail++;
            $display("FAIL mask_hold: got pend=%b busy=%b takes=%0d mask=%b, expected 0001 0 0 1110", pend_q, busy, n_take - t0, mask_q);
        end
        exp_q.push_back(10'h3C0);
        mask_we = 1'b1; mask_d = 4'b1111;
        cyc(1);
        mask_we = 1'b0;
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3C0 || pend_q !== 4'b0000) begin
            n_fail++;
            $display("FAIL mask_unmask_enter: got take=%b vec=%h pend=%b, expected 1 3c0 0000", take, vec, pend_q);
        end
        cyc(1);
        ret_pulse();
        irq_src[0] = 1'b0;
        // Re-arm source 1 so its next edge lands in the cycle that clears it.
        mask_we = 1'b1; mask_d = 4'b1101;
        cyc(1);
        mask_we = 1'b0;
        irq_src[1] = 1'b1;
        cyc(3);
        n_tests++;
        if (pend_q !== 4'b0010 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_pend1: got pend=%b busy=%b, expected 0010 0", pend_q, busy);
        end
        irq_src[1] = 1'b0;
        cyc(3);
        irq_src[1] = 1'b1;
        exp_q.push_back(10'h3C4);
        exp_q.push_back(10'h3C4);
        cyc(1);
        mask_we = 1'b1; mask_d = 4'b1111;
        cyc(1);
        mask_we = 1'b0;
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3C4 || pend_q !== 4'b0010) begin
            n_fail++;
            $display("FAIL set_wins: got take=%b vec=%h pend=%b, expected 1 3c4 0010", take, vec, pend_q);
        end
        cyc(1);
        ret_pulse();
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || pend_q !== 4'b0000) begin
            n_fail++;
            $display("FAIL set_wins_reenter: got take=%b pend=%b, expected 1 0000", take, pend_q);
        end
        cyc(1);
        ret_pulse();
        irq_src[1] = 1'b0;
        cyc(3);
    endtask

    task automatic test_ret_ignored();
        ret = 1'b1;
        #1;
        n_tests++;
        if (pc_ret_sel !== 1'b0 || z_restore !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_idle: got sel=%b zr=%b, expected 0 0", pc_ret_sel, z_restore);
        end
        cyc(1);
        ret = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || take !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_idle_state: got busy=%b take=%b, expected 0 0", busy, take);
        end
        irq_src[2] = 1'b1;
        exp_q.push_back(10'h3C8);
        cyc(4);
        ret = 1'b1;
        #1;
        n_tests++;
        if (take !== 1'b1 || pc_ret_sel !== 1'b0 || z_restore !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_enter: got take=%b sel=%b zr=%b, expected 1 0 0", take, pc_ret_sel, z_restore);
        end
        cyc(1);
        ret = 1'b0;
        cyc(1);
        n_tests++;
        if (busy !== 1'b1 || take !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_enter_state: got busy=%b take=%b, expected 1 0", busy, take);
        end
        irq_src[2] = 1'b0;
        cyc(3);
        irq_src[2] = 1'b1;
        exp_q.push_back(10'h3C8);
        cyc(3);
        n_tests++;
        if (pend_q !== 4'b0100 || busy !== 1'b1 || take !== 1'b0) begin
            n_fail++;
            $display("FAIL active_edge: got pend=%b busy=%b take=%b, expected 0100 1 0", pend_q, busy, take);
        end
        ret_pulse();
        cyc(1);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3C8) begin
            n_fail++;
            $display("FAIL active_edge_service: got take=%b vec=%h, expected 1 3c8", take, vec);
        end
        cyc(1);
        ret_pulse();
        irq_src[2] = 1'b0;
        cyc(3);
    endtask

    task automatic test_level();
        int t0;
        t0 = n_take;
        irq_src[3] = 1'b1;
        exp_q.push_back(10'h3CC);
        cyc(5);
        ret_pulse();
        cyc(20);
        n_tests++;
        if (n_take - t0 !== 1 || pend_q !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL level_once: got takes=%0d pend=%b busy=%b, expected 1 0000 0", n_take - t0, pend_q, busy);
        end
        irq_src[3] = 1'b0;
        cyc(3);
        irq_src[3] = 1'b1;
        exp_q.push_back(10'h3CC);
        cyc(4);
        n_tests++;
        if (take !== 1'b1 || vec !== 10'h3CC) begin
            n_fail++;
            $display("FAIL level_repulse: got take=%b vec=%h, expected 1 3cc", take, vec);
        end
        cyc(1);
        ret_pulse();
        cyc(5);
        n_tests++;
        if (n_take - t0 !== 2) begin
            n_fail++;
            $display("FAIL level_count: got %0d takes, expected 2", n_take - t0);
        end
        irq_src[3] = 1'b0;
        cyc(3);
    endtask

    task automatic test_reset_mid_active();
        int t0;
        pc_next = 10'h2B7; z_in = 1'b1;
        irq_src[0] = 1'b1;
        exp_q.push_back(10'h3C0);
        cyc(5);
        irq_src[2] = 1'b1;
        cyc(3);
        n_tests++;
        if (busy !== 1'b1 || pend_q !== 4'b0100 || pc_ret !== 10'h2B7 || z_ret !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got busy=%b pend=%b pc_ret=%h z_ret=%b, expected 1 0100 2b7 1", busy, pend_q, pc_ret, z_ret);
        end
        irq_src = 4'b0000;
        ret = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({take, vec, pc_ret_sel, pc_ret, z_restore, z_ret, mask_q, pend_q, busy} !== 30'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got take=%b vec=%h sel=%b pc_ret=%h zr=%b z_ret=%b mask=%b pend=%b busy=%b, expected all 0",
                     take, vec, pc_ret_sel, pc_ret, z_restore, z_ret, mask_q, pend_q, busy);
        end
        ret = 1'b0;
        cyc(2);
        reset = 1'b0;
        mask_we = 1'b1; mask_d = 4'b1111;
        cyc(1);
        mask_we = 1'b0;
        t0 = n_take;
        cyc(6);
        n_tests++;
        if (n_take !== t0 || busy !== 1'b0 || pend_q !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_after: got takes=%0d busy=%b pend=%b, expected 0 0 0000", n_take - t0, busy, pend_q);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_ret_ignored();
        test_level();
        test_reset_mid_active();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d unserviced entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
